// File: rtl/an_residue_barrett.sv
// AN-code residue checker: three-stage Barrett reduction of a received codeword
// modulo A, with valid/ready flow control and saturating word/error counters.
module an_residue_barrett #(
    parameter int A = 13,
    parameter int N = 6,
    parameter int R = 4,
    parameter int K = 8,
    parameter int M = 19
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_codeword,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_codeword,
    output logic [R-1:0] out_residue,
    output logic         out_err,
    output logic [7:0]   word_cnt,
    output logic [7:0]   err_cnt
);

    localparam int            PW      = N + 5;
    localparam int            QW      = PW - K;
    localparam logic [R:0]    A_R     = (R+1)'(A);
    localparam logic [PW-1:0] M_P     = PW'(M);
    localparam logic [7:0]    CNT_MAX = 8'hFF;

    // Barrett remainder lies in [0, 2A), so one conditional subtract finishes it.
    function automatic logic [R-1:0] fold_residue(input logic [R:0] r);
        logic [R:0] t;
        if (r >= A_R) begin
            t = r - A_R;
        end else begin
            t = r;
        end
        return t[R-1:0];
    endfunction

    logic          advance_s;
    logic [PW-1:0] p_s;
    logic [QW-1:0] q_s;
    logic [N-1:0]  qa_s;
    logic [R:0]    r_s;
    logic [R-1:0]  res_s;

    logic          v1_r;
    logic [N-1:0]  x1_r;
    logic [PW-1:0] p1_r;
    logic          v2_r;
    logic [N-1:0]  x2_r;
    logic [R:0]    r2_r;

    // Global pipeline advance and per-stage arithmetic.
    always_comb begin
        advance_s = !out_valid || out_ready;
        in_ready  = advance_s;
        p_s       = PW'(in_codeword) * M_P;
        q_s       = QW'(p1_r >> K);
        qa_s      = N'(q_s * A);
        r_s       = (R+1)'(x1_r - qa_s);
        res_s     = fold_residue(r2_r);
    end

    // Pipeline stages: all load together on advance, all hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r         <= 1'b0;
            x1_r         <= {N{1'b0}};
            p1_r         <= {PW{1'b0}};
            v2_r         <= 1'b0;
            x2_r         <= {N{1'b0}};
            r2_r         <= {(R+1){1'b0}};
            out_valid    <= 1'b0;
            out_codeword <= {N{1'b0}};
            out_residue  <= {R{1'b0}};
            out_err      <= 1'b0;
        end else if (advance_s) begin
            v1_r         <= in_valid;
            x1_r         <= in_codeword;
            p1_r         <= p_s;
            v2_r         <= v1_r;
            x2_r         <= x1_r;
            r2_r         <= r_s;
            out_valid    <= v2_r;
            out_codeword <= x2_r;
            out_residue  <= res_s;
            out_err      <= (res_s != {R{1'b0}});
        end
    end

    // Saturating transfer counters; input and output sides count independently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= 8'd0;
            err_cnt  <= 8'd0;
        end else begin
            if (in_valid && advance_s && (word_cnt != CNT_MAX)) begin
                word_cnt <= word_cnt + 8'd1;
            end
            if (out_valid && out_ready && out_err && (err_cnt != CNT_MAX)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_an_residue_barrett.sv
// Directed testbench for an_residue_barrett: hand-computed residues, stall,
// mid-flight reset and counter saturation.
module tb_an_residue_barrett;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_codeword;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_codeword;
    logic [3:0] out_residue;
    logic       out_err;
    logic [7:0] word_cnt;
    logic [7:0] err_cnt;

    int checks   = 0;
    int failures = 0;
    int in_q[$];
    int cw_q[$];
    int exp_q[$];
    int cyc;

    an_residue_barrett #(.A(13), .N(6), .R(4), .K(8), .M(19)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_codeword  (in_codeword),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_codeword (out_codeword),
        .out_residue  (out_residue),
        .out_err      (out_err),
        .word_cnt     (word_cnt),
        .err_cnt      (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int x, input int res);
        in_q.push_back(x);
        cw_q.push_back(x);
        exp_q.push_back(res);
    endtask

    // Called at a negedge; holds reset across one rising edge, releases at a negedge.
    task automatic do_reset(input string tag);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_word_cnt"}, 32'(word_cnt), 32'd0);
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        check({tag, "_residue"}, 32'(out_residue), 32'd0);
        check({tag, "_codeword"}, 32'(out_codeword), 32'd0);
        check({tag, "_err"}, 32'(out_err), 32'd0);
        rst_n = 1'b1;
    endtask

    // Streams in_q, checks each output transfer against cw_q/exp_q in order,
    // optionally stalling out_ready for stall_len cycles once out_valid rises.
    task automatic run_stream(input string tag, input int stall_len, output int cycles);
        int         stall_left;
        bit         in_stall;
        logic       ov;
        logic [5:0] held_cw;
        logic [3:0] held_res;
        stall_left = stall_len;
        in_stall   = 1'b0;
        cycles     = 0;
        held_cw    = 6'd0;
        held_res   = 4'd0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && cycles < 2000) begin
            ov = out_valid;
            if (ov && stall_left > 0) begin
                out_ready = 1'b0;
                if (!in_stall) begin
                    held_cw  = out_codeword;
                    held_res = out_residue;
                    in_stall = 1'b1;
                end else begin
                    check({tag, "_stall_cw"}, 32'(out_codeword), 32'(held_cw));
                    check({tag, "_stall_res"}, 32'(out_residue), 32'(held_res));
                end
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            if (ov && out_ready) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_extra_out"}, 32'(out_valid), 32'd0);
                end else begin
                    check({tag, "_res"}, 32'(out_residue), 32'(exp_q[0]));
                    check({tag, "_err"}, 32'(out_err), 32'(exp_q[0] != 0));
                    check({tag, "_cw"}, 32'(out_codeword), 32'(cw_q[0]));
                    void'(exp_q.pop_front());
                    void'(cw_q.pop_front());
                end
            end
            if (in_q.size() > 0) begin
                in_valid    = 1'b1;
                in_codeword = 6'(in_q[0]);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check({tag, "_in_ready"}, 32'(in_ready), 32'(!ov || out_ready));
            if (in_valid && in_ready) void'(in_q.pop_front());
            @(negedge clk);
            cycles++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({tag, "_drained"}, 32'(in_q.size() + exp_q.size()), 32'd0);
        in_q.delete();
        cw_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        in_codeword = 6'd0;
        @(negedge clk);
        do_reset("reset0");

        // Single word 27: 27 mod 13 = 1, visible three edges after accept.
        in_valid    = 1'b1;
        in_codeword = 6'd27;
        @(negedge clk);
        in_valid = 1'b0;
        check("single_word_cnt", 32'(word_cnt), 32'd1);
        check("single_lat1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("single_lat2", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_res", 32'(out_residue), 32'd1);
        check("single_err", 32'(out_err), 32'd1);
        check("single_cw", 32'(out_codeword), 32'd27);
        @(negedge clk);
        check("single_drained", 32'(out_valid), 32'd0);
        check("single_err_cnt", 32'(err_cnt), 32'd1);

        // Boundaries and multiples of 13.
        do_reset("reset1");
        push(0, 0);
        push(13, 0);
        push(26, 0);
        push(52, 0);
        push(63, 11);
        run_stream("bnd", 0, cyc);
        check("bnd_cycles", 32'(cyc), 32'd8);
        check("bnd_word_cnt", 32'(word_cnt), 32'd5);
        check("bnd_err_cnt", 32'(err_cnt), 32'd1);

        // Exhaustive codeword sweep.
        do_reset("reset2");
        for (int x = 0; x < 64; x++) push(x, x % 13);
        run_stream("exh", 0, cyc);
        check("exh_cycles", 32'(cyc), 32'd67);
        check("exh_word_cnt", 32'(word_cnt), 32'd64);
        check("exh_err_cnt", 32'(err_cnt), 32'd59);

        // Back-pressure for four cycles after the first output.
        do_reset("reset3");
        for (int i = 0; i < 10; i++) push(20 + i, (20 + i) % 13);
        run_stream("stall", 4, cyc);
        check("stall_cycles", 32'(cyc), 32'd17);
        check("stall_word_cnt", 32'(word_cnt), 32'd10);
        check("stall_err_cnt", 32'(err_cnt), 32'd9);

        // Reset with three words in flight, then a lone word 14.
        do_reset("reset4");
        in_valid    = 1'b1;
        in_codeword = 6'd27;
        @(negedge clk);
        in_codeword = 6'd40;
        @(negedge clk);
        in_codeword = 6'd50;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("flight_valid", 32'(out_valid), 32'd1);
        check("flight_word_cnt", 32'(word_cnt), 32'd3);
        do_reset("midrst");
        push(14, 1);
        run_stream("after_rst", 0, cyc);
        check("after_rst_cycles", 32'(cyc), 32'd4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("after_rst_idle", 32'(out_valid), 32'd0);
        end
        check("after_rst_word_cnt", 32'(word_cnt), 32'd1);
        check("after_rst_err_cnt", 32'(err_cnt), 32'd1);

        // Saturation: 300 words, residues 1..12.
        do_reset("reset5");
        for (int i = 0; i < 300; i++) push(1 + (i % 12), 1 + (i % 12));
        run_stream("sat", 0, cyc);
        check("sat_cycles", 32'(cyc), 32'd303);
        check("sat_word_cnt", 32'(word_cnt), 32'd255);
        check("sat_err_cnt", 32'(err_cnt), 32'd255);
        @(negedge clk);
        @(negedge clk);
        check("sat_word_hold", 32'(word_cnt), 32'd255);
        check("sat_err_hold", 32'(err_cnt), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/an_residue_barrett.md
AN_RESIDUE_BARRETT -- requirements
Module: an_residue_barrett

Interface
REQ-001 Parameter A, default 13: AN-code multiplier (modulus).
REQ-002 Parameter N, default 6: codeword width.
REQ-003 Parameter R, default 4: residue width, ceil(log2(A)).
REQ-004 Parameter K, default 8: Barrett shift, 2*R.
REQ-005 Parameter M, default 19: Barrett constant, floor(2**K / A).
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 in_valid  input  1  codeword on in_codeword is valid.
REQ-009 in_ready  output  1  block accepts a codeword this cycle.
REQ-010 in_codeword  input  N  received AN codeword.
REQ-011 out_valid  output  1  out_codeword/out_residue/out_err are valid.
REQ-012 out_ready  input  1  downstream decoder consumes the output this cycle.
REQ-013 out_codeword  output  N  codeword delayed to align with its residue.
REQ-014 out_residue  output  R  in_codeword mod A, range 0..A-1.
REQ-015 out_err  output  1  out_residue nonzero.
REQ-016 word_cnt  output  8  accepted-codeword count, saturating.
REQ-017 err_cnt  output  8  count of emitted words with out_err=1, saturating.

Function
REQ-018 Transfers: input accepted when in_valid&&in_ready; output consumed when out_valid&&out_ready.
REQ-019 Three-stage pipeline, each stage holding a valid bit; latency 3 cycles from accept to out_valid, with no stall.
REQ-020 Global advance = !out_valid || out_ready; in_ready = advance, combinational, no dependence on in_valid.
REQ-021 On advance, every stage loads from its predecessor, and stage-1 valid loads in_valid; when advance=0, all stages hold.
REQ-022 Stage 1 registers x=in_codeword and the product p=x*M, width N+5 bits (11 at defaults, max 1197).
REQ-023 Stage 2 registers q=p>>K (3 bits at defaults) and r=x-q*A, R+1 bits, guaranteed 0 <= r < 2A.
REQ-024 Stage 3 registers out_residue = (r>=A) ? r-A : r, together with out_codeword=x and out_err=(residue!=0).
REQ-025 Full throughput: one word per cycle while out_ready=1; back-to-back words are never dropped, duplicated or reordered.
REQ-026 Outputs are stable while out_valid=1 and out_ready=0.
REQ-027 Data registers of invalid stages may hold stale values; only valid bits gate transfers and counters.
REQ-028 word_cnt increments on each input transfer; err_cnt increments on each output transfer with out_err=1.
REQ-029 Both counters saturate at 255 and never wrap.
REQ-030 An input transfer and an output transfer in the same cycle both count.
REQ-031 Boundary x=0 gives residue 0.
REQ-032 Exact multiples of A (13, 26, 39, 52) take the correction path (r=A) and give residue 0.
REQ-033 x=2**N-1 (63) gives residue 11.

Reset
REQ-034 rst_n low immediately clears all stage valid bits, out_valid, out_codeword, out_residue, out_err, word_cnt and err_cnt to 0.
REQ-035 During reset, in_ready reads 1.
REQ-036 Reset mid-operation discards all in-flight words, with no output transfer for them.
REQ-037 First acceptance may occur on the first rising edge after rst_n deasserts.

Verification
REQ-038 Scenario: out_ready=1, single in_codeword=27 -> 3 cycles later out_valid=1, out_residue=1, out_err=1, out_codeword=27.
REQ-039 Scenario: stream 0,13,26,52,63, out_ready=1 -> residues 0,0,0,0,11 on consecutive cycles; out_err 0,0,0,0,1; err_cnt=1, word_cnt=5.
REQ-040 Scenario: exhaustive x=0..63 streamed -> each out_residue equals x%13 in order; err_cnt=59, word_cnt=64.
REQ-041 Scenario: continuous input, out_ready=0 for 4 cycles after first out_valid -> in_ready=0 in those cycles, outputs held stable, no words lost or reordered after release.
REQ-042 Scenario: rst_n pulsed low with 3 words in flight -> out_valid=0 and counters=0 immediately; the next accepted word 14 emerges alone with residue 1.
REQ-043 Scenario: 300 accepted words, all nonzero residue -> word_cnt=255 and err_cnt=255, held.
